// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: in-order imem requests, PC/instr holding, redirect flush with in-flight drop.
// Latency: response -> valid_o next cycle (same cycle when FETCH_BUFFER_BYPASS_EN is defined).
// Backpressure: stall_i holds the head entry; requests stop while DEPTH entries are allocated.
//
// Ports: clk_i/rst_i (sync active-high reset); imem_req_o/imem_addr_o/imem_gnt_i issue fetches;
// imem_rvalid_i/imem_rdata_i return words in order; redirect_i/redirect_pc_i squash and restart;
// stall_i is decode backpressure; valid_o/instr_o/pc_o present the buffer head to decode.
// Optional macro: FETCH_BUFFER_BYPASS_EN adds a same-cycle response-to-decode path.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE     = PW'(1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [63:0]    fetch_pc;
    logic [PW-1:0]  wptr, fptr, rptr, drop_cnt;
    logic [63:0]    ent_pc    [DEPTH];
    logic [31:0]    ent_instr [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    logic [AW-1:0]  widx, fidx, ridx;
    logic [PW-1:0]  occupancy;
    logic           grant, head_filled, consume, byp, byp_consume;

    assign widx = wptr[AW-1:0];
    assign fidx = fptr[AW-1:0];
    assign ridx = rptr[AW-1:0];

    // Allocated-but-not-consumed entries; pointers are one bit wider so full != empty.
    assign occupancy   = wptr - rptr;
    assign imem_req_o  = ~rst_i & ~redirect_i & (occupancy < DEPTH_P);
    assign imem_addr_o = fetch_pc;
    assign grant       = imem_req_o & imem_gnt_i;

    // Consumed entries have filled cleared, so a stale head from a previous lap never reads valid.
    assign head_filled = ent_filled[ridx];

`ifdef FETCH_BUFFER_BYPASS_EN
    // A live response landing on an empty head goes straight to decode.
    assign byp = imem_rvalid_i & (drop_cnt == '0) & ~redirect_i & ~head_filled & (rptr == fptr);
`else
    assign byp = 1'b0;
`endif

    assign valid_o     = ~rst_i & ~redirect_i & (head_filled | byp);
    assign instr_o     = byp ? imem_rdata_i : ent_instr[ridx];
    assign pc_o        = ent_pc[ridx];
    assign consume     = valid_o & ~stall_i;
    assign byp_consume = byp & consume;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc   <= RESET_PC;
            wptr       <= '0;
            fptr       <= '0;
            rptr       <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]    <= '0;
                ent_instr[i] <= '0;
            end
        end else if (redirect_i) begin
            // Everything granted but not yet returned becomes garbage; a response in this
            // very cycle is itself discarded, so it leaves the count.
            rptr       <= wptr;
            fptr       <= wptr;
            ent_filled <= '0;
            fetch_pc   <= redirect_pc_i;
            drop_cnt   <= drop_cnt + (wptr - fptr) - PW'(imem_rvalid_i);
        end else begin
            if (grant) begin
                ent_pc[widx]     <= fetch_pc;
                ent_filled[widx] <= 1'b0;
                wptr             <= wptr + ONE;
                fetch_pc         <= fetch_pc + 64'd4;
            end
            if (imem_rvalid_i) begin
                if (drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - ONE;
                end else begin
                    fptr <= fptr + ONE;
                    if (!byp_consume) begin
                        ent_instr[fidx]  <= imem_rdata_i;
                        ent_filled[fidx] <= 1'b1;
                    end
                end
            end
            if (consume) begin
                rptr             <= rptr + ONE;
                ent_filled[ridx] <= 1'b0;
            end
        end
    end

    // A response with nothing outstanding and nothing to drop is a memory protocol error.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(imem_rvalid_i && (drop_cnt == '0) && (fptr == wptr)));
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
`ifdef FETCH_BUFFER_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;

    always #5 clk = ~clk;

    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
        .valid_o(valid), .instr_o(instr), .pc_o(pc)
    );

    // Memory side: every granted fetch with the epoch it belongs to and when it returns.
    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } pend_t;
    // Decode side: instructions decode must see, in order, and from which cycle.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        int          ready;
    } exp_t;

    pend_t pend[$];
    exp_t  expq[$];
    int    epoch = 0;
    int    alloc = 0;
    logic [63:0] fpc = RESET_PC;
    int    now = 0;
    int    errors = 0;
    int    checks = 0;

    int          stall_pct, gnt_pct, lat_min, lat_max;
    bit          data_fixed;
    logic [31:0] data_val;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, expv, now);
        end
    endtask

    task automatic step(input bit redir, input logic [63:0] rpc);
        bit          gnt, rv, exp_req, exp_vld;
        pend_t       p;
        int          due;
        logic [31:0] gdata;
        @(posedge clk);
        #1;
        now++;
        rst         = 1'b0;
        redirect    = redir;
        redirect_pc = rpc;
        stall       = ($urandom_range(99) < stall_pct);
        gnt         = (pend.size() < DEPTH) && ($urandom_range(99) < gnt_pct);
        imem_gnt    = gnt;
        rv          = (pend.size() > 0) && (pend[0].due <= now);
        imem_rvalid = rv;
        imem_rdata  = rv ? pend[0].data : $urandom;
        gdata       = data_fixed ? data_val : $urandom;
        @(negedge clk);
        if (rv) begin
            p = pend.pop_front();
            if (!redir && p.epoch == epoch)
                expq.push_back('{pc: p.addr, instr: p.data, ready: now + LAT});
        end
        exp_req = !redir && (alloc < DEPTH);
        exp_vld = !redir && (expq.size() > 0) && (expq[0].ready <= now);
        chk("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, fpc);
        chk("valid", {63'd0, valid}, {63'd0, exp_vld});
        if (exp_vld) begin
            chk("pc", pc, expq[0].pc);
            chk("instr", {32'd0, instr}, {32'd0, expq[0].instr});
        end
        if (exp_vld && !stall) begin
            void'(expq.pop_front());
            alloc--;
        end
        if (exp_req && gnt) begin
            due = now + $urandom_range(lat_max, lat_min);
            if (pend.size() > 0 && due <= pend[$].due) due = pend[$].due + 1;
            pend.push_back('{addr: fpc, data: gdata, epoch: epoch, due: due});
            alloc++;
            fpc = fpc + 64'd4;
        end
        if (redir) begin
            expq.delete();
            epoch++;
            alloc = 0;
            fpc   = rpc;
        end
    endtask

    initial begin
        rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_pc", pc, 64'd0);
        chk("rst_addr", imem_addr, RESET_PC);

        // Stream: immediate grant, 1-cycle memory, no stall.
        stall_pct = 0; gnt_pct = 100; lat_min = 1; lat_max = 1;
        data_fixed = 1'b1; data_val = 32'h0000_0013;
        repeat (20) step(1'b0, '0);

        // Fill and stall, then drain.
        stall_pct = 100;
        repeat (12) step(1'b0, '0);
        stall_pct = 0;
        repeat (10) step(1'b0, '0);

        // Redirect with in-flight requests whose data must never surface.
        lat_min = 3; lat_max = 3; data_val = 32'hDEAD_BEEF;
        repeat (3) step(1'b0, '0);
        data_val = 32'h0000_0013;
        step(1'b1, 64'h0000_0000_8000_1000);
        repeat (10) step(1'b0, '0);

        // Back-to-back redirects with responses still in flight.
        repeat (3) step(1'b0, '0);
        step(1'b1, 64'h0000_0000_8000_3000);
        step(1'b1, 64'h0000_0000_8000_4000);
        repeat (10) step(1'b0, '0);

        // Redirect while stalled and full.
        lat_min = 1; lat_max = 1; stall_pct = 100;
        repeat (10) step(1'b0, '0);
        step(1'b1, 64'h0000_0000_8000_2000);
        stall_pct = 0;
        repeat (8) step(1'b0, '0);

        // Fetch PC wraps past the top of the address space.
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        repeat (10) step(1'b0, '0);

        // Randomized traffic.
        stall_pct = 30; gnt_pct = 70; lat_min = 1; lat_max = 4; data_fixed = 1'b0;
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(99) < 5), {$urandom, $urandom} & ~64'h3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
